// File: rtl/firebird7_in_gate1_hdspsr_trim_apply_ctrl.sv
// HDSPSR array trim apply sequencer: selects fuse or IJTAG override trim and
// applies changes through a hold / shutoff / load / settle / release handshake.
module firebird7_in_gate1_hdspsr_trim_apply_ctrl #(
  parameter int TRIM_W      = 19,
  parameter int PRE_CYC     = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              fuse_valid,
  input  logic [TRIM_W-1:0] fuse_trim,
  input  logic              ovrd_en,
  input  logic [TRIM_W-1:0] ovrd_trim,
  input  logic              hold_ack,
  input  logic              clear_err,
  output logic              hold_req,
  output logic              shutoff_force,
  output logic [TRIM_W-1:0] trim_out,
  output logic              busy,
  output logic              update_done,
  output logic              ack_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SHUT,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRIM_W-1:0] tgt_q, tgt_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              shut_q, shut_d;
  logic              busy_q, busy_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              upd_q, upd_d;

  logic [TRIM_W-1:0] target;
  logic              eligible;
  logic              err_set;

  // Sequencer next-state, counter and target snapshot
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    err_set  = 1'b0;
    target   = ovrd_en ? ovrd_trim : fuse_trim;
    eligible = ovrd_en | fuse_valid;
    case (state_q)
      S_IDLE: begin
        if (eligible && !err_q && (target != trim_q)) begin
          tgt_d   = target;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (hold_ack) begin
          cnt_d   = '0;
          state_d = S_SHUT;
        end else if (cnt_q == ACK_LAST) begin
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SHUT: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; trim/done take one more stage so the
  // trim word moves only while shutoff is already asserted on the pins
  always_comb begin
    hold_d = state_q inside {S_REQ, S_SHUT, S_LOAD, S_SETTLE};
    shut_d = state_q inside {S_SHUT, S_LOAD, S_SETTLE};
    busy_d = (state_q != S_IDLE);
    load_d = (state_q == S_LOAD);
    done_d = (state_q == S_DONE);
    upd_d  = done_q;
    trim_d = load_q ? tgt_q : trim_q;
    err_d  = clear_err ? 1'b0 : (err_q | err_set);
  end

  // State and output registers
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      trim_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      shut_q  <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      trim_q  <= trim_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      shut_q  <= shut_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
    end
  end

  assign hold_req        = hold_q;
  assign shutoff_force   = shut_q;
  assign trim_out        = trim_q;
  assign busy            = busy_q;
  assign update_done     = upd_q;
  assign ack_timeout_err = err_q;

endmodule
